// File: rtl/bcd_ripple_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ripple_counter_ctrl
// Description : BCD counter with one-digit-per-clock carry ripple and a
//               req/ack increment handshake; count_out updates atomically.
// Revision    : 1.0
// ============================================================================
module bcd_ripple_counter_ctrl #(
    parameter int DIGITS = 3,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic                  inc_req,
    output logic                  inc_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   count_out
);

    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RIPPLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    logic [4*DIGITS-1:0]   r_work;
    logic [4*DIGITS-1:0]   r_count;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_ovf_pend;
    logic                  r_inc_ack;
    logic                  r_done;
    logic                  r_overflow;

    logic [4*DIGITS-1:0]   w_load_clamped;
    logic [DIGITS-1:0]     w_dig_nine;
    logic                  w_all_nines;
    logic [3:0]            w_digit;

    // Per-digit clamp of out-of-range BCD load values and all-nines detect.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        assign w_load_clamped[4*gi +: 4] =
            (load_data[4*gi +: 4] > 4'd9) ? 4'd9 : load_data[4*gi +: 4];
        assign w_dig_nine[gi] = (r_work[4*gi +: 4] == 4'd9);
    end

    assign w_all_nines = &w_dig_nine;
    assign w_digit     = r_work[{r_idx, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_work     <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_ovf_pend <= 1'b0;
            r_inc_ack  <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_inc_ack  <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            if (clear) begin
                r_state    <= ST_IDLE;
                r_work     <= '0;
                r_count    <= '0;
                r_idx      <= '0;
                r_ovf_pend <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (load) begin
                            r_work  <= w_load_clamped;
                            r_count <= w_load_clamped;
                        end else if (inc_req) begin
                            r_inc_ack <= 1'b1;
                            if ((WRAP == 0) && w_all_nines) begin
                                r_ovf_pend <= 1'b1;
                                r_state    <= ST_DONE;
                            end else begin
                                r_ovf_pend <= 1'b0;
                                r_idx      <= '0;
                                r_state    <= ST_RIPPLE;
                            end
                        end
                    end
                    ST_RIPPLE: begin
                        if (w_digit < 4'd9) begin
                            r_work[{r_idx, 2'b00} +: 4] <= w_digit + 4'd1;
                            r_state <= ST_DONE;
                        end else begin
                            r_work[{r_idx, 2'b00} +: 4] <= 4'd0;
                            if (r_idx == c_last_idx) begin
                                r_ovf_pend <= 1'b1;
                                r_state    <= ST_DONE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        // Single publish point keeps ripple intermediates hidden.
                        r_done     <= 1'b1;
                        r_overflow <= r_ovf_pend;
                        r_count    <= r_work;
                        r_ovf_pend <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign inc_ack   = r_inc_ack;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign count_out = r_count;

endmodule
`default_nettype wire

// File: tb/tb_bcd_ripple_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_ripple_counter_ctrl
// Description : Directed vector table plus hand-written multi-cycle sequences.
// Revision    : 1.0
// ============================================================================
module tb_bcd_ripple_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        load;
    logic [11:0] load_data;
    logic        inc_req;

    logic        inc_ack, busy, done, overflow;
    logic [11:0] count_out;
    logic        s_inc_ack, s_busy, s_done, s_overflow;
    logic [11:0] s_count_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bcd_ripple_counter_ctrl #(.DIGITS(3), .WRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
        .load_data(load_data), .inc_req(inc_req), .inc_ack(inc_ack),
        .busy(busy), .done(done), .overflow(overflow), .count_out(count_out)
    );

    bcd_ripple_counter_ctrl #(.DIGITS(3), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
        .load_data(load_data), .inc_req(inc_req), .inc_ack(s_inc_ack),
        .busy(s_busy), .done(s_done), .overflow(s_overflow), .count_out(s_count_out)
    );

    typedef struct {
        logic        clr;
        logic        ld;
        logic [11:0] ldd;
        logic        inc;
        logic [11:0] cnt;
        logic        ack;
        logic        bsy;
        logic        dn;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic add(logic clr, logic ld, logic [11:0] ldd, logic inc,
                       logic [11:0] cnt, logic ack, logic bsy, logic dn, logic ovf);
        vec_t v;
        v.clr = clr; v.ld = ld; v.ldd = ldd; v.inc = inc;
        v.cnt = cnt; v.ack = ack; v.bsy = bsy; v.dn = dn; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic check(string name, logic [11:0] a_cnt, logic a_ack, logic a_bsy,
                         logic a_dn, logic a_ovf, logic [11:0] e_cnt, logic e_ack,
                         logic e_bsy, logic e_dn, logic e_ovf);
        tests++;
        if ({a_cnt, a_ack, a_bsy, a_dn, a_ovf} !== {e_cnt, e_ack, e_bsy, e_dn, e_ovf}) begin
            fails++;
            $display("FAIL %s: got cnt=%h ack=%b busy=%b done=%b ovf=%b, expected cnt=%h ack=%b busy=%b done=%b ovf=%b",
                     name, a_cnt, a_ack, a_bsy, a_dn, a_ovf, e_cnt, e_ack, e_bsy, e_dn, e_ovf);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; load = 1'b0; load_data = 12'h000; inc_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear = 1'b0; load = 1'b1; load_data = 12'h123; inc_req = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        int accepts, dones, ovfs, exp_val;
        logic prev_busy;

        //   clr ld  ldd     inc  cnt     ack bsy dn ovf
        add(0, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0);
        add(0, 1, 12'h259, 0, 12'h259, 0, 0, 0, 0);
        add(0, 0, 12'h000, 1, 12'h259, 1, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h259, 0, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h259, 0, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h260, 0, 0, 1, 0);
        add(0, 1, 12'hA5F, 0, 12'h959, 0, 0, 0, 0);
        add(0, 1, 12'h999, 0, 12'h999, 0, 0, 0, 0);
        add(0, 0, 12'h000, 1, 12'h999, 1, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h999, 0, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h999, 0, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h999, 0, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h000, 0, 0, 1, 1);
        add(0, 1, 12'h099, 0, 12'h099, 0, 0, 0, 0);
        add(0, 0, 12'h000, 1, 12'h099, 1, 1, 0, 0);
        add(0, 1, 12'h555, 0, 12'h099, 0, 1, 0, 0);
        add(1, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0);
        add(0, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0);
        add(0, 0, 12'h000, 1, 12'h000, 1, 1, 0, 0);
        add(0, 0, 12'h000, 1, 12'h000, 0, 1, 0, 0);
        add(0, 0, 12'h000, 0, 12'h001, 0, 0, 1, 0);
        add(1, 1, 12'h777, 1, 12'h000, 0, 0, 0, 0);
        add(0, 0, 12'h000, 0, 12'h000, 0, 0, 0, 0);

        idle_inputs();
        rst_n = 1'b1;
        do_reset();
        check("reset", count_out, inc_ack, busy, done, overflow,
              12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            clear = vecs[i].clr; load = vecs[i].ld;
            load_data = vecs[i].ldd; inc_req = vecs[i].inc;
            step();
            check($sformatf("vec%0d", i), count_out, inc_ack, busy, done, overflow,
                  vecs[i].cnt, vecs[i].ack, vecs[i].bsy, vecs[i].dn, vecs[i].ovf);
        end
        idle_inputs();

        // Saturating variant: all-nines increment finishes one cycle after accept.
        do_reset();
        load = 1'b1; load_data = 12'h999;
        step();
        load = 1'b0; inc_req = 1'b1;
        step();
        check("sat_accept", s_count_out, s_inc_ack, s_busy, s_done, s_overflow,
              12'h999, 1'b1, 1'b1, 1'b0, 1'b0);
        inc_req = 1'b0;
        step();
        check("sat_done", s_count_out, s_inc_ack, s_busy, s_done, s_overflow,
              12'h999, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        check("sat_after", s_count_out, s_inc_ack, s_busy, s_done, s_overflow,
              12'h999, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous inc_req from zero through one full wrap.
        clear = 1'b1;
        step();
        clear = 1'b0;
        inc_req = 1'b1;
        accepts = 0; dones = 0; ovfs = 0; exp_val = 0;
        prev_busy = busy;
        for (int cyc = 0; cyc < 10000 && dones < 1000; cyc++) begin
            step();
            if (inc_ack) begin
                accepts++;
                tests++;
                if (prev_busy) begin
                    fails++;
                    $display("FAIL accept_while_busy: got ack with busy=1 at accept %0d, expected no ack", accepts);
                end
                if (accepts == 1000) inc_req = 1'b0;
            end
            if (done) begin
                exp_val = (exp_val + 1) % 1000;
                dones++;
                check($sformatf("run_done%0d", dones), count_out, 1'b0, 1'b0, 1'b0,
                      overflow, to_bcd(exp_val), 1'b0, 1'b0, 1'b0, (exp_val == 0));
                if (overflow) ovfs++;
            end else if (count_out !== to_bcd(exp_val) || overflow) begin
                tests++;
                fails++;
                $display("FAIL run_stable: got cnt=%h ovf=%b, expected cnt=%h ovf=0",
                         count_out, overflow, to_bcd(exp_val));
            end
            prev_busy = busy;
        end
        inc_req = 1'b0;
        tests++;
        if (accepts != 1000 || dones != 1000) begin
            fails++;
            $display("FAIL run_counts: got accepts=%0d dones=%0d, expected 1000/1000", accepts, dones);
        end
        tests++;
        if (ovfs != 1) begin
            fails++;
            $display("FAIL run_overflows: got %0d, expected 1", ovfs);
        end
        step();
        check("run_final", count_out, inc_ack, busy, done, overflow,
              12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
